// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared encodings and defaults for the pipeline sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int DEF_CNT_W        = 32;
   localparam int DEF_DRAIN_CYCLES = 4;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Datapath <-> sequencer bundle: stage fields in, enables out.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             enable;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_rs_used;
   logic             id_rt_used;
   logic [4:0]       ex_waddr;
   logic [4:0]       mem_waddr;
   logic [4:0]       wb_waddr;
   logic             ex_reg_write;
   logic             mem_reg_write;
   logic             wb_reg_write;
   logic             mem_branch;
   logic             mem_zero;
   logic             mem_jump;
   logic             pc_en;
   logic             if_id_en;
   logic             pipe_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic [1:0]       state;
   logic             busy;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output enable, id_rs, id_rt, id_rs_used, id_rt_used,
             ex_waddr, mem_waddr, wb_waddr,
             ex_reg_write, mem_reg_write, wb_reg_write,
             mem_branch, mem_zero, mem_jump,
      input  pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
             state, busy, cycle_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      input  enable, id_rs, id_rt, id_rs_used, id_rt_used,
             ex_waddr, mem_waddr, wb_waddr,
             ex_reg_write, mem_reg_write, wb_reg_write,
             mem_branch, mem_zero, mem_jump,
      output pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
             state, busy, cycle_cnt, stall_cnt, flush_cnt
   );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : RAW check of ID sources against EXE/MEM/WB destinations.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
   import cpu_ctrl_pkg::*;
(
   input  wire logic [4:0] i_rs,
   input  wire logic [4:0] i_rt,
   input  wire logic       i_rs_used,
   input  wire logic       i_rt_used,
   input  wire logic [4:0] i_ex_waddr,
   input  wire logic [4:0] i_mem_waddr,
   input  wire logic [4:0] i_wb_waddr,
   input  wire logic       i_ex_we,
   input  wire logic       i_mem_we,
   input  wire logic       i_wb_we,
   output wire logic       o_hazard
);
   logic w_rs_hit;
   logic w_rt_hit;

   // WB is included: the register file only commits at the edge, so a read
   // in the same cycle would still see the stale value.
   assign w_rs_hit = i_rs_used && (i_rs != REG_ZERO) &&
                     ((i_ex_we  && (i_ex_waddr  == i_rs)) ||
                      (i_mem_we && (i_mem_waddr == i_rs)) ||
                      (i_wb_we  && (i_wb_waddr  == i_rs)));

   assign w_rt_hit = i_rt_used && (i_rt != REG_ZERO) &&
                     ((i_ex_we  && (i_ex_waddr  == i_rt)) ||
                      (i_mem_we && (i_mem_waddr == i_rt)) ||
                      (i_wb_we  && (i_wb_waddr  == i_rt)));

   assign o_hazard = w_rs_hit || w_rt_hit;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : 5-stage pipeline sequencer: stall/squash control, run/drain
//               FSM and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
)(
   input  wire logic       clk,
   input  wire logic       arst,
   pipeline_ctrl_if.slave  bus
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]    c_drain_load = DW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [DW-1:0]    r_drain_cnt;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_hazard;
   logic             w_redirect;
   logic             w_start;

   hazard_detect u_hazard_detect (
      .i_rs        (bus.id_rs),
      .i_rt        (bus.id_rt),
      .i_rs_used   (bus.id_rs_used),
      .i_rt_used   (bus.id_rt_used),
      .i_ex_waddr  (bus.ex_waddr),
      .i_mem_waddr (bus.mem_waddr),
      .i_wb_waddr  (bus.wb_waddr),
      .i_ex_we     (bus.ex_reg_write),
      .i_mem_we    (bus.mem_reg_write),
      .i_wb_we     (bus.wb_reg_write),
      .o_hazard    (w_hazard)
   );

   assign w_redirect = (bus.mem_branch && bus.mem_zero) || bus.mem_jump;
   assign w_start    = (r_state == ST_IDLE) && bus.enable;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.enable) w_state_nxt = ST_RUN;
         ST_RUN:   if (!bus.enable) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (bus.enable)              w_state_nxt = ST_RUN;
            else if (r_drain_cnt == '0)  w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.pipe_en      = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_flush  = 1'b0;
      bus.ex_mem_flush = 1'b0;
      if ((r_state == ST_RUN || r_state == ST_DRAIN) && w_redirect) begin
         // PC loads the target while the three wrong-path slots are squashed.
         bus.pc_en        = 1'b1;
         bus.if_id_en     = 1'b1;
         bus.pipe_en      = 1'b1;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_flush  = 1'b1;
         bus.ex_mem_flush = 1'b1;
      end else if (r_state == ST_DRAIN || (r_state == ST_RUN && w_hazard)) begin
         bus.pipe_en      = 1'b1;
         bus.id_ex_flush  = 1'b1;
      end else if (r_state == ST_RUN) begin
         bus.pc_en        = 1'b1;
         bus.if_id_en     = 1'b1;
         bus.pipe_en      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_drain_cnt <= '0;
      end else if (r_state == ST_RUN && !bus.enable) begin
         r_drain_cnt <= c_drain_load;
      end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
         r_drain_cnt <= r_drain_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (w_start) begin
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
         if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
         if (w_redirect) begin
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + c_cnt_one;
         end else if (w_hazard && r_state == ST_RUN) begin
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + c_cnt_one;
         end
      end
   end

   assign bus.state     = r_state;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.cycle_cnt = r_cycle_cnt;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Randomised + directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
   localparam int CW   = 5;
   localparam int DC   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic clk;
   logic arst;

   pipeline_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) u_dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check_eq(input string tag, input longint unsigned got,
                           input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0=idle, 1=run, 2=drain
   int m_mode, m_drain, m_cyc, m_stall, m_flush;

   function automatic bit f_hazard();
      logic [4:0] src[2];
      bit         used[2];
      logic [4:0] wa[3];
      bit         wv[3];
      src  = '{bus.id_rs, bus.id_rt};
      used = '{bus.id_rs_used, bus.id_rt_used};
      wa   = '{bus.ex_waddr, bus.mem_waddr, bus.wb_waddr};
      wv   = '{bus.ex_reg_write, bus.mem_reg_write, bus.wb_reg_write};
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 3; w++)
            if (used[s] && src[s] != 0 && wv[w] && wa[w] == src[s]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit f_redirect();
      return (bus.mem_branch && bus.mem_zero) || bus.mem_jump;
   endfunction

   function automatic int sat(input int v);
      return (v >= MAXC) ? MAXC : v + 1;
   endfunction

   // {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush}
   function automatic logic [5:0] f_exp_ctrl();
      if (m_mode == 0)  return 6'b000_000;
      if (f_redirect()) return 6'b111_111;
      if (m_mode == 2 || f_hazard()) return 6'b001_010;
      return 6'b111_000;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_drain = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_clock();
      bit redir, haz;
      redir = f_redirect();
      haz   = f_hazard();
      case (m_mode)
         0: if (bus.enable) begin
               m_mode = 1; m_cyc = 0; m_stall = 0; m_flush = 0;
            end
         1: begin
               m_cyc = sat(m_cyc);
               if (redir)    m_flush = sat(m_flush);
               else if (haz) m_stall = sat(m_stall);
               if (!bus.enable) begin m_mode = 2; m_drain = DC - 1; end
            end
         default: begin
               m_cyc = sat(m_cyc);
               if (redir) m_flush = sat(m_flush);
               if (bus.enable)       m_mode = 1;
               else if (m_drain == 0) m_mode = 0;
               else                  m_drain--;
            end
      endcase
   endtask

   task automatic check_all();
      check_eq("ctrl", {bus.pc_en, bus.if_id_en, bus.pipe_en,
                        bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush},
               f_exp_ctrl());
      check_eq("state", bus.state, m_mode);
      check_eq("busy", bus.busy, m_mode != 0);
      check_eq("cycle_cnt", bus.cycle_cnt, m_cyc);
      check_eq("stall_cnt", bus.stall_cnt, m_stall);
      check_eq("flush_cnt", bus.flush_cnt, m_flush);
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (!arst) model_clock();
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
      bus.ex_waddr = 0; bus.mem_waddr = 0; bus.wb_waddr = 0;
      bus.ex_reg_write = 0; bus.mem_reg_write = 0; bus.wb_reg_write = 0;
      bus.mem_branch = 0; bus.mem_zero = 0; bus.mem_jump = 0;
   endtask

   task automatic rand_inputs();
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_rs_used = 1'($urandom);
      bus.id_rt_used = 1'($urandom);
      bus.ex_waddr  = 5'($urandom_range(0, 3));
      bus.mem_waddr = 5'($urandom_range(0, 3));
      bus.wb_waddr  = 5'($urandom_range(0, 3));
      bus.ex_reg_write  = 1'($urandom);
      bus.mem_reg_write = 1'($urandom);
      bus.wb_reg_write  = 1'($urandom);
      bus.mem_branch = ($urandom_range(0, 5) == 0);
      bus.mem_zero   = 1'($urandom);
      bus.mem_jump   = ($urandom_range(0, 11) == 0);
   endtask

   initial begin
      arst = 1'b0;
      bus.enable = 1'b0;
      clear_inputs();
      model_reset();

      // Reset with activity on the inputs: everything must read zero.
      #2 arst = 1'b1;
      bus.enable = 1'b1;
      rand_inputs();
      #1 check_all();
      @(negedge clk);
      check_all();
      @(posedge clk);
      #1 arst = 1'b0;
      clear_inputs();

      // Start, then 10 RUN cycles.
      step();
      check_eq("run_state", bus.state, 1);
      check_eq("run_pc_en", bus.pc_en, 1);
      repeat (10) step();
      check_eq("cycle_cnt_10", bus.cycle_cnt, 10);

      // Producer of r1 walks EXE -> MEM -> WB directly ahead of its consumer.
      bus.id_rs = 5'd1; bus.id_rs_used = 1'b1;
      bus.ex_waddr = 5'd1; bus.ex_reg_write = 1'b1;
      #1 check_eq("raw_ex_pc_en", bus.pc_en, 0);
      step();
      bus.ex_reg_write = 1'b0;
      bus.mem_waddr = 5'd1; bus.mem_reg_write = 1'b1;
      step();
      bus.mem_reg_write = 1'b0;
      bus.wb_waddr = 5'd1; bus.wb_reg_write = 1'b1;
      #1 check_eq("raw_wb_flush", bus.id_ex_flush, 1);
      step();
      bus.wb_reg_write = 1'b0;
      #1 check_eq("raw_done_pc_en", bus.pc_en, 1);
      step();
      check_eq("stall_cnt_3", bus.stall_cnt, 3);

      // r0 is never a dependency.
      clear_inputs();
      bus.id_rs_used = 1'b1; bus.ex_waddr = 5'd0; bus.ex_reg_write = 1'b1;
      #1 check_eq("r0_pc_en", bus.pc_en, 1);
      step();

      // Jump in MEM coinciding with a hazard: only a flush is counted.
      clear_inputs();
      bus.id_rt = 5'd2; bus.id_rt_used = 1'b1;
      bus.ex_waddr = 5'd2; bus.ex_reg_write = 1'b1; bus.mem_jump = 1'b1;
      #1 check_eq("redir_ctrl", {bus.pc_en, bus.if_id_flush, bus.id_ex_flush,
                                 bus.ex_mem_flush}, 4'b1111);
      step();
      check_eq("redir_flush_cnt", bus.flush_cnt, 1);
      check_eq("redir_stall_cnt", bus.stall_cnt, 3);

      // Full drain to IDLE.
      clear_inputs();
      bus.enable = 1'b0;
      step();
      for (int i = 0; i < DC; i++) begin
         check_eq("drain_state", bus.state, 2);
         check_eq("drain_en", {bus.pc_en, bus.pipe_en}, 2'b01);
         step();
      end
      check_eq("drain_idle", bus.state, 0);
      check_eq("drain_busy", bus.busy, 0);

      // Abandoned drain resumes RUN.
      bus.enable = 1'b1;
      repeat (3) step();
      bus.enable = 1'b0;
      repeat (3) step();
      check_eq("resume_drain", bus.state, 2);
      bus.enable = 1'b1;
      #1 check_eq("resume_frozen", {bus.pc_en, bus.if_id_en}, 2'b00);
      step();
      check_eq("resume_run", bus.state, 1);
      check_eq("resume_pc_en", bus.pc_en, 1);
      check_eq("resume_cyc", bus.cycle_cnt, 6);

      // Reset in the middle of a drain.
      bus.enable = 1'b0;
      repeat (2) step();
      #2 arst = 1'b1;
      model_reset();
      #1 check_eq("arst_state", bus.state, 0);
      check_all();
      @(posedge clk);
      #1 arst = 1'b0;

      // Stall counter saturation under a held hazard.
      bus.enable = 1'b1;
      step();
      bus.id_rs = 5'd3; bus.id_rs_used = 1'b1;
      bus.wb_waddr = 5'd3; bus.wb_reg_write = 1'b1;
      repeat (MAXC + 3) step();
      check_eq("stall_sat", bus.stall_cnt, MAXC);
      check_eq("cycle_sat", bus.cycle_cnt, MAXC);

      // Random traffic with sticky enable.
      for (int i = 0; i < 2000; i++) begin
         rand_inputs();
         if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule : tb_pipeline_ctrl
`default_nettype wire
